load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port: takes one load/store per handshake from the core pipeline,
//  drives word-aligned address, byte enables and lane-shifted write data to the data memory.
//  Returns sign/zero-extended load data. Sits between the execute stage and the data memory.
//  Multi-cycle: memory handshake is req/ack, so memories with wait states are supported.
// PARAMETERS
//  DM_ADDRESS  9   byte-address width to memory; addresses wrap modulo 2**DM_ADDRESS
//  DATA_W      32  data width; fixed 32 (4 byte lanes), other values unsupported
// PORTS
//  clk        in   1           single clock; all state on posedge
//  reset      in   1           synchronous, active-high
//  req_valid  in   1           pipeline request valid
//  req_ready  out  1           high only in IDLE; request accepted when req_valid&&req_ready
//  req_load   in   1           1=load, 0=store
//  req_funct3 in   3           instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr   in   DM_ADDRESS  byte address (ALU result LSBs)
//  req_wdata  in   DATA_W      store data, LSB-justified
//  resp_valid out  1           one-cycle pulse, completion of accepted request
//  resp_rdata out  DATA_W      extended load data; 0 for stores and errors
//  resp_err   out  1           qualified by resp_valid: illegal funct3 or misaligned
//  mem_req    out  1           held high until mem_ack
//  mem_we     out  1           store access
//  mem_addr   out  DM_ADDRESS  word-aligned address ([1:0]=00)
//  mem_be     out  4           byte-lane write enables (0000 on loads)
//  mem_wdata  out  DATA_W      lane-shifted write data
//  mem_ack    in   1           access done; mem_rdata valid same cycle on loads
//  mem_rdata  in   DATA_W      full word read data
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0,
//   mem_addr=0, mem_be=0, mem_wdata=0. Reset mid-access drops mem_req next edge; later acks ignored.
//  FSM: IDLE -accept-> ACC0 (or RESP if error) ; ACC0 -ack-> RESP or ACC1 ; ACC1 -ack-> RESP ; RESP -> IDLE.
//  Request fields registered at accept; inputs ignored outside IDLE. mem_ack ignored outside ACC0/ACC1.
//  Lanes: off=addr[1:0]; base mask B=0001,H=0011,W=1111; mem_be=(mask<<off)[3:0]; wdata<<8*off.
//  Load extract: (mem_rdata>>8*off), then sign-extend from bit 7/15 (000/001) or zero-extend (100/101).
//  Illegal: funct3 011/110/111; stores with 100/101. -> RESP with resp_err=1, no memory access.
//  Misaligned: H with off=3, W with off!=0 (handling under CONFIGURATION).
//  Latency (aligned, ack in first req cycle): accept T, mem_req T+1, resp_valid T+2. Wait states add 1:1.
//  Back-to-back: next request accepted in cycle after resp_valid (IDLE); throughput 1 per 3 cycles min.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined: misaligned access split into two word accesses. ACC0 at addr&~3 with
//   lanes (mask<<off)[3:0]; ACC1 at (addr&~3)+4 (wraps modulo 2**DM_ADDRESS) with lanes (mask<<off)[7:4];
//   write data split the same way; load bytes from both words merged, then extended. resp_err=0.
//  Undefined: misaligned -> no memory access, RESP with resp_err=1, resp_rdata=0.
// STRUCTURE
//  lsu_pkg: state enum (IDLE,ACC0,ACC1,RESP), funct3 localparams, function lane_mask(funct3,off)
//   returning 8-bit mask, function is_misaligned(funct3,off).
//  Sub-module lsu_lane_align: combinational 64-bit lane shifter/merger + sign/zero extender;
//   FSM and registers stay in load_store_unit.
// TESTING
//  SB addr 0x005 wdata 0x000000A7 -> mem_addr 0x004, be 0010, mem_wdata 0x0000A700; resp_err=0.
//  LB addr 0x006, mem_rdata 0x00800000 -> resp_rdata 0xFFFFFF80; same with LBU -> 0x00000080.
//  LW addr 0x010, ack delayed 3 cycles -> mem_req held 4 cycles, resp_valid 1 cycle after ack, no early resp.
//  funct3 011 load -> resp_valid T+1 with resp_err=1, mem_req never asserted.
//  LW addr 0x1FE: with macro -> ACC0 0x1FC, ACC1 0x000 (wrap), rdata {w1[15:0],w0[31:16]};
//   without macro -> resp_err=1, no access.
//  reset asserted while mem_req high awaiting ack -> next cycle IDLE, all outputs reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and lane helpers for the load/store unit
// Contents: FSM state enum, funct3 encodings, lane_mask(), is_misaligned(), is_illegal().
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes touched across two consecutive words: [3:0] first word, [7:4] next word.
  function automatic logic [7:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [7:0] base;
    case (funct3)
      F3_B, F3_BU: base = 8'b0000_0001;
      F3_H, F3_HU: base = 8'b0000_0011;
      F3_W:        base = 8'b0000_1111;
      default:     base = 8'b0000_0000;
    endcase
    return base << off;
  endfunction

  // True when the access would spill into the next word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: return (off == 2'd3);
      F3_W:        return (off != 2'd0);
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned widths only exist for loads; 011/110/111 are never legal.
  function automatic logic is_illegal(input logic [2:0] funct3, input logic load);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return !load;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational lane shifter, two-word merger and load extender
// Ports: i_wdata/i_wr_off -> o_wdata64 (store data shifted into lanes of two words);
//        i_rdata_lo/i_rdata_hi/i_rd_off/i_rd_funct3 -> o_rdata (extracted, extended load data).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_wr_off,
  output logic [63:0] o_wdata64,
  input  logic [2:0]  i_rd_funct3,
  input  logic [1:0]  i_rd_off,
  input  logic [31:0] i_rdata_lo,
  input  logic [31:0] i_rdata_hi,
  output logic [31:0] o_rdata
);

  logic [63:0] w_rd_cat;
  logic [31:0] w_rd_word;

  assign o_wdata64 = {32'h0, i_wdata} << {i_wr_off, 3'b000};

  // Lower word holds the first-addressed bytes; a word-crossing load pulls its
  // upper bytes from the following word.
  assign w_rd_cat  = {i_rdata_hi, i_rdata_lo};
  assign w_rd_word = 32'(w_rd_cat >> {i_rd_off, 3'b000});

  always_comb begin
    o_rdata = 32'h0;
    case (i_rd_funct3)
      F3_B:    o_rdata = {{24{w_rd_word[7]}}, w_rd_word[7:0]};
      F3_H:    o_rdata = {{16{w_rd_word[15]}}, w_rd_word[15:0]};
      F3_W:    o_rdata = w_rd_word;
      F3_BU:   o_rdata = {24'h0, w_rd_word[7:0]};
      F3_HU:   o_rdata = {16'h0, w_rd_word[15:0]};
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: one load/store per handshake over req/ack memory
// Ports: clk, reset (sync, active-high); pipeline side req_valid/req_ready/req_load/req_funct3/
//        req_addr/req_wdata, resp_valid/resp_rdata/resp_err; memory side mem_req/mem_we/mem_addr/
//        mem_be/mem_wdata, mem_ack/mem_rdata.
// Macro: LSU_MISALIGN_SPLIT_EN - word-crossing accesses become two word accesses instead of errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_e            r_state;
  logic                  r_load;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;
  logic                  r_split;
  logic [3:0]            r_be_hi;
  logic [DM_ADDRESS-1:0] r_addr_hi;
  logic [DATA_W-1:0]     r_wdata_hi;
  logic [DATA_W-1:0]     r_w0;

  logic [1:0]            w_off;
  logic [7:0]            w_mask;
  logic                  w_err;
  logic [DM_ADDRESS-1:0] w_base;
  logic [63:0]           w_wdata64;
  logic [DATA_W-1:0]     w_rd_lo;
  logic [DATA_W-1:0]     w_rd_hi;
  logic [DATA_W-1:0]     w_rdata_ext;

  assign req_ready = (r_state == IDLE);
  assign w_off     = req_addr[1:0];
  assign w_mask    = lane_mask(req_funct3, w_off);
  assign w_base    = {req_addr[DM_ADDRESS-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_err = is_illegal(req_funct3, req_load);
`else
  assign w_err = is_illegal(req_funct3, req_load) || is_misaligned(req_funct3, w_off);
`endif

  // In ACC1 the first word was captured earlier; the live read data is the second word.
  assign w_rd_lo = (r_state == ACC1) ? r_w0 : mem_rdata;
  assign w_rd_hi = (r_state == ACC1) ? mem_rdata : '0;

  lsu_lane_align u_align (
    .i_wdata     (req_wdata),
    .i_wr_off    (w_off),
    .o_wdata64   (w_wdata64),
    .i_rd_funct3 (r_funct3),
    .i_rd_off    (r_off),
    .i_rdata_lo  (w_rd_lo),
    .i_rdata_hi  (w_rd_hi),
    .o_rdata     (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_load     <= 1'b0;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
      r_split    <= 1'b0;
      r_be_hi    <= 4'b0000;
      r_addr_hi  <= '0;
      r_wdata_hi <= '0;
      r_w0       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_load     <= req_load;
            r_funct3   <= req_funct3;
            r_off      <= w_off;
            resp_rdata <= '0;
            if (w_err) begin
              // Rejected requests never touch memory.
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              r_state    <= ACC0;
              resp_err   <= 1'b0;
              mem_req    <= 1'b1;
              mem_we     <= ~req_load;
              mem_addr   <= w_base;
              mem_be     <= req_load ? 4'b0000 : w_mask[3:0];
              mem_wdata  <= w_wdata64[31:0];
              r_be_hi    <= req_load ? 4'b0000 : w_mask[7:4];
              r_wdata_hi <= w_wdata64[63:32];
              r_addr_hi  <= w_base + DM_ADDRESS'(4);
              r_split    <= |w_mask[7:4];
            end
          end
        end
        ACC0, ACC1: begin
          if (mem_ack) begin
            if (r_state == ACC0 && r_split) begin
              // Keep mem_req high and retarget to the following word.
              r_state   <= ACC1;
              mem_addr  <= r_addr_hi;
              mem_be    <= r_be_hi;
              mem_wdata <= r_wdata_hi;
              r_w0      <= mem_rdata;
            end else begin
              r_state    <= RESP;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= '0;
              mem_be     <= 4'b0000;
              mem_wdata  <= '0;
              resp_valid <= 1'b1;
              resp_rdata <= r_load ? w_rdata_ext : '0;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with byte-level reference model
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int DM_ADDRESS = 9;
  localparam int DATA_W     = 32;
  localparam int MEM_BYTES  = 512;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_load;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic                  mem_req;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] dut_mem [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  logic        got_ready, got_rv_idle, got_err, got_timeout;
  logic [31:0] got_rdata;
  int          got_lat, got_req_cycles, got_nacc;
  logic [8:0]  got_addr  [2];
  logic [3:0]  got_be    [2];
  logic        got_we    [2];
  logic [31:0] got_wdata [2];

  logic        exp_err;
  logic [31:0] exp_rdata;
  int          exp_nacc;
  logic [8:0]  exp_addr  [2];
  logic [3:0]  exp_be    [2];
  logic [31:0] exp_wdata [2];

  // Reference: walk the accessed bytes one by one, group them by containing word.
  task automatic model(input logic load, input logic [2:0] f3, input logic [8:0] addr,
                       input logic [31:0] wdata);
    int size, a, w;
    logic illegal, crosses;
    logic [31:0] val;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : (f3[1:0] == 2'b10) ? 4 : 0;
    illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (!load && f3[2]);
    crosses = (size > 0) && ((int'(addr) % 4) + size > 4);
    exp_err = illegal || (crosses && !SPLIT);
    exp_nacc = 0;
    exp_rdata = 32'h0;
    val = 32'h0;
    for (int k = 0; k < 2; k++) begin
      exp_addr[k] = 9'h0; exp_be[k] = 4'h0; exp_wdata[k] = 32'h0;
    end
    if (!exp_err) begin
      for (int i = 0; i < size; i++) begin
        a = (int'(addr) + i) % MEM_BYTES;
        w = a - (a % 4);
        if (exp_nacc == 0 || int'(exp_addr[exp_nacc-1]) != w) begin
          exp_addr[exp_nacc] = 9'(w);
          exp_nacc++;
        end
        if (!load) begin
          exp_be[exp_nacc-1][a % 4] = 1'b1;
          exp_wdata[exp_nacc-1][8*(a % 4) +: 8] = wdata[8*i +: 8];
          ref_mem[a] = wdata[8*i +: 8];
        end else begin
          val[8*i +: 8] = ref_mem[a];
        end
      end
      if (load) begin
        if (size == 1)      exp_rdata = f3[2] ? {24'h0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
        else if (size == 2) exp_rdata = f3[2] ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
        else                exp_rdata = val;
      end
    end
  endtask

  task automatic preload(input int waddr, input logic [31:0] w);
    for (int l = 0; l < 4; l++) begin
      dut_mem[waddr + l] = w[8*l +: 8];
      ref_mem[waddr + l] = w[8*l +: 8];
    end
  endtask

  // Issues one request and acts as the memory; records what the DUT did.
  task automatic run_txn(input logic load, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wdata, input int dly);
    int wait_cnt;
    @(negedge clk);
    got_ready   = req_ready;
    got_rv_idle = resp_valid;
    req_valid = 1'b1; req_load = load; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    got_nacc = 0; got_req_cycles = 0; got_timeout = 1'b1; got_lat = -1; wait_cnt = 0;
    got_err = 1'bx; got_rdata = 32'hx;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (resp_valid) begin
        got_timeout = 1'b0; got_lat = cyc; got_err = resp_err; got_rdata = resp_rdata;
        break;
      end
      req_valid  = mem_req ? 1'($urandom) : 1'b0;
      req_load   = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = 9'($urandom);
      req_wdata  = $urandom;
      if (mem_req) begin
        got_req_cycles++;
        if (wait_cnt == 0 && got_nacc < 2) begin
          got_addr[got_nacc] = mem_addr; got_be[got_nacc] = mem_be;
          got_we[got_nacc] = mem_we; got_wdata[got_nacc] = mem_wdata;
        end
        if (wait_cnt >= dly) begin
          mem_ack = 1'b1;
          for (int l = 0; l < 4; l++) mem_rdata[8*l +: 8] = dut_mem[(int'(mem_addr) + l) % MEM_BYTES];
          if (mem_we)
            for (int l = 0; l < 4; l++)
              if (mem_be[l]) dut_mem[(int'(mem_addr) + l) % MEM_BYTES] = mem_wdata[8*l +: 8];
          got_nacc++;
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom; wait_cnt++;
        end
      end else begin
        mem_ack = 1'($urandom); mem_rdata = $urandom;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready  !== 1'b1)  begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0)  begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err   !== 1'b0)  begin failures++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if (mem_req    !== 1'b0)  begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_we     !== 1'b0)  begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr   !== 9'h0)  begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_be     !== 4'h0)  begin failures++; $display("FAIL rst_mem_be got=%b exp=0", mem_be); end
    checks++; if (mem_wdata  !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_spec_vectors();
    model(1'b0, 3'b000, 9'h005, 32'h000000A7);
    run_txn(1'b0, 3'b000, 9'h005, 32'h000000A7, 0);
    checks++; if (got_addr[0]  !== 9'h004)       begin failures++; $display("FAIL sb_addr got=%h exp=004", got_addr[0]); end
    checks++; if (got_be[0]    !== 4'b0010)      begin failures++; $display("FAIL sb_be got=%b exp=0010", got_be[0]); end
    checks++; if (got_wdata[0] !== 32'h0000A700) begin failures++; $display("FAIL sb_wdata got=%h exp=0000a700", got_wdata[0]); end
    checks++; if (got_we[0]    !== 1'b1)         begin failures++; $display("FAIL sb_we got=%b exp=1", got_we[0]); end
    checks++; if (got_err      !== 1'b0)         begin failures++; $display("FAIL sb_err got=%b exp=0", got_err); end
    checks++; if (got_lat      !== 1)            begin failures++; $display("FAIL sb_latency got=%0d exp=1", got_lat); end

    preload(4, 32'h00800000);
    run_txn(1'b1, 3'b000, 9'h006, 32'h0, 0);
    checks++; if (got_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", got_rdata); end
    checks++; if (got_be[0] !== 4'b0000)      begin failures++; $display("FAIL lb_be got=%b exp=0000", got_be[0]); end
    run_txn(1'b1, 3'b100, 9'h006, 32'h0, 0);
    checks++; if (got_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", got_rdata); end

    preload(16, 32'h12345678);
    run_txn(1'b1, 3'b010, 9'h010, 32'h0, 3);
    checks++; if (got_req_cycles !== 4)            begin failures++; $display("FAIL lw_wait_req_cycles got=%0d exp=4", got_req_cycles); end
    checks++; if (got_lat        !== 4)            begin failures++; $display("FAIL lw_wait_latency got=%0d exp=4", got_lat); end
    checks++; if (got_rdata      !== 32'h12345678) begin failures++; $display("FAIL lw_wait_rdata got=%h exp=12345678", got_rdata); end

    run_txn(1'b1, 3'b011, 9'h020, 32'h0, 0);
    checks++; if (got_lat        !== 0)     begin failures++; $display("FAIL illegal_latency got=%0d exp=0", got_lat); end
    checks++; if (got_err        !== 1'b1)  begin failures++; $display("FAIL illegal_err got=%b exp=1", got_err); end
    checks++; if (got_req_cycles !== 0)     begin failures++; $display("FAIL illegal_mem_req got=%0d exp=0", got_req_cycles); end
    checks++; if (got_rdata      !== 32'h0) begin failures++; $display("FAIL illegal_rdata got=%h exp=0", got_rdata); end

    preload(9'h1FC, 32'hAABBCCDD);
    preload(0, 32'h11223344);
    run_txn(1'b1, 3'b010, 9'h1FE, 32'h0, 1);
    checks++; if (got_err   !== !SPLIT) begin failures++; $display("FAIL lw_wrap_err got=%b exp=%b", got_err, !SPLIT); end
    checks++; if (got_nacc  !== (SPLIT ? 2 : 0)) begin failures++; $display("FAIL lw_wrap_nacc got=%0d exp=%0d", got_nacc, SPLIT ? 2 : 0); end
    checks++; if (got_rdata !== (SPLIT ? 32'h3344AABB : 32'h0)) begin failures++; $display("FAIL lw_wrap_rdata got=%h exp=%h", got_rdata, SPLIT ? 32'h3344AABB : 32'h0); end
    checks++; if ((got_nacc == 2 ? {got_addr[0], got_addr[1]} : 18'h0) !== (SPLIT ? {9'h1FC, 9'h000} : 18'h0)) begin
      failures++; $display("FAIL lw_wrap_addrs got=%h,%h nacc=%0d", got_addr[0], got_addr[1], got_nacc);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] a;
    a = {5'($urandom), 4'b0000} | 9'h100;
    model(1'b0, 3'b010, a, 32'hCAFEF00D);
    run_txn(1'b0, 3'b010, a, 32'hCAFEF00D, 0);
    checks++; if (got_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", got_ready); end
    model(1'b0, 3'b001, a + 9'd2, 32'h00005A5A);
    run_txn(1'b0, 3'b001, a + 9'd2, 32'h00005A5A, 0);
    checks++; if (got_ready   !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", got_ready); end
    checks++; if (got_rv_idle !== 1'b0) begin failures++; $display("FAIL b2b_resp_pulse got=%b exp=0", got_rv_idle); end
    checks++; if (got_be[0] !== 4'b1100) begin failures++; $display("FAIL b2b_sh_be got=%b exp=1100", got_be[0]); end
    model(1'b1, 3'b010, a, 32'h0);
    run_txn(1'b1, 3'b010, a, 32'h0, 0);
    checks++; if (got_ready !== 1'b1)  begin failures++; $display("FAIL b2b_ready2 got=%b exp=1", got_ready); end
    checks++; if (got_lat   !== 1)     begin failures++; $display("FAIL b2b_latency got=%0d exp=1", got_lat); end
    checks++; if (got_rdata !== exp_rdata) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", got_rdata, exp_rdata); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 9'h020; mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL mid_mem_req_up got=%b exp=1", mem_req); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_req    !== 1'b0) begin failures++; $display("FAIL mid_mem_req_drop got=%b exp=0", mem_req); end
    checks++; if (req_ready  !== 1'b1) begin failures++; $display("FAIL mid_req_ready got=%b exp=1", req_ready); end
    checks++; if (mem_addr   !== 9'h0) begin failures++; $display("FAIL mid_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_resp_valid got=%b exp=0", resp_valid); end
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_late_ack_resp got=%b exp=0", resp_valid); end
    checks++; if (mem_req    !== 1'b0) begin failures++; $display("FAIL mid_late_ack_req got=%b exp=0", mem_req); end
    model(1'b1, 3'b001, 9'h022, 32'h0);
    run_txn(1'b1, 3'b001, 9'h022, 32'h0, 0);
    checks++; if (got_rdata !== exp_rdata) begin failures++; $display("FAIL mid_recover_rdata got=%h exp=%h", got_rdata, exp_rdata); end
  endtask

  task automatic test_random();
    logic        load;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata, lm;
    int          dly;
    for (int i = 0; i < 300; i++) begin
      load  = 1'($urandom);
      f3    = 3'($urandom);
      addr  = 9'($urandom);
      wdata = $urandom;
      dly   = $urandom_range(0, 3);
      model(load, f3, addr, wdata);
      run_txn(load, f3, addr, wdata, dly);
      checks++; if (got_timeout !== 1'b0) begin failures++; $display("FAIL rnd[%0d] timeout got=%b exp=0", i, got_timeout); end
      checks++; if (got_ready !== 1'b1) begin failures++; $display("FAIL rnd[%0d] ready got=%b exp=1", i, got_ready); end
      checks++; if (got_rv_idle !== 1'b0) begin failures++; $display("FAIL rnd[%0d] resp_pulse got=%b exp=0", i, got_rv_idle); end
      checks++; if (got_err !== exp_err) begin failures++; $display("FAIL rnd[%0d] err got=%b exp=%b", i, got_err, exp_err); end
      checks++; if (got_rdata !== exp_rdata) begin failures++; $display("FAIL rnd[%0d] rdata got=%h exp=%h (f3=%b addr=%h)", i, got_rdata, exp_rdata, f3, addr); end
      checks++; if (got_nacc !== exp_nacc) begin failures++; $display("FAIL rnd[%0d] accesses got=%0d exp=%0d", i, got_nacc, exp_nacc); end
      checks++; if (got_lat !== exp_nacc * (dly + 1)) begin failures++; $display("FAIL rnd[%0d] latency got=%0d exp=%0d", i, got_lat, exp_nacc * (dly + 1)); end
      checks++; if (got_req_cycles !== exp_nacc * (dly + 1)) begin failures++; $display("FAIL rnd[%0d] req_cycles got=%0d exp=%0d", i, got_req_cycles, exp_nacc * (dly + 1)); end
      for (int k = 0; k < exp_nacc && k < got_nacc; k++) begin
        for (int l = 0; l < 4; l++) lm[8*l +: 8] = {8{exp_be[k][l]}};
        checks++; if (got_addr[k] !== exp_addr[k]) begin failures++; $display("FAIL rnd[%0d] acc%0d addr got=%h exp=%h", i, k, got_addr[k], exp_addr[k]); end
        checks++; if (got_be[k] !== exp_be[k]) begin failures++; $display("FAIL rnd[%0d] acc%0d be got=%b exp=%b", i, k, got_be[k], exp_be[k]); end
        checks++; if (got_we[k] !== !load) begin failures++; $display("FAIL rnd[%0d] acc%0d we got=%b exp=%b", i, k, got_we[k], !load); end
        checks++; if ((got_wdata[k] & lm) !== exp_wdata[k]) begin failures++; $display("FAIL rnd[%0d] acc%0d wdata got=%h exp=%h", i, k, got_wdata[k] & lm, exp_wdata[k]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    for (int b = 0; b < MEM_BYTES; b++) begin
      dut_mem[b] = 8'($urandom);
      ref_mem[b] = dut_mem[b];
    end
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
